// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and arbiter state type for the register-file write-back arbiter.
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic {
    PRI_A,
    FORCE_B
  } arb_state_e;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back requester/register-file bundle; sb_* signals exist only with RF_WB_SCOREBOARD_EN.
interface rf_wb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  localparam int NUM_REGS = 2 ** REG_AW;

  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;
  logic              rf_reg_write;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_write_data;
`ifdef RF_WB_SCOREBOARD_EN
  logic                sb_alloc;
  logic [REG_AW-1:0]   sb_alloc_rd;
  logic [NUM_REGS-1:0] sb_busy;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, sb_alloc, sb_alloc_rd,
    input  a_ready, b_ready, rf_reg_write, rf_rd, rf_write_data, sb_busy
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, sb_alloc, sb_alloc_rd,
    output a_ready, b_ready, rf_reg_write, rf_rd, rf_write_data, sb_busy
  );
`else
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_reg_write, rf_rd, rf_write_data
  );
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_reg_write, rf_rd, rf_write_data
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy-register scoreboard: alloc sets, write-back clears, alloc wins on collision, x0 never busy.
module rf_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_i,
  input  logic [REG_AW-1:0]      alloc_rd_i,
  input  logic                   clr_i,
  input  logic [REG_AW-1:0]      clr_rd_i,
  output logic [2**REG_AW-1:0]   busy_o
);
  logic [2**REG_AW-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i && clr_rd_i != '0) busy_d[clr_rd_i] = 1'b0;
    if (alloc_i && alloc_rd_i != '0) busy_d[alloc_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Fixed-priority (A over B) write-back arbiter with B starvation protection and registered RF write.
// Optional scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_AW     = rf_pkg::REG_AW,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  wb
);
  localparam int                CW          = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]     STARVE_LAST = CW'(STARVE_MAX - 1);

  arb_state_e        state_q;
  logic [CW-1:0]     starve_q;
  logic              grant_a, grant_b, win_we;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  logic              rf_we_q;
  logic [REG_AW-1:0] rf_rd_q;
  logic [XLEN-1:0]   rf_data_q;

  // Grants are gated by rst so both readies read 0 while reset is held.
  always_comb begin
    grant_a  = rst && (state_q == PRI_A) && wb.a_valid;
    grant_b  = rst && wb.b_valid && ((state_q == FORCE_B) || !wb.a_valid);
    win_rd   = grant_b ? wb.b_rd   : wb.a_rd;
    win_data = grant_b ? wb.b_data : wb.a_data;
    win_we   = (grant_a || grant_b) && (win_rd != '0);
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PRI_A;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= win_we;
      if (win_we) begin
        rf_rd_q   <= win_rd;
        rf_data_q <= win_data;
      end
      unique case (state_q)
        PRI_A: begin
          if (wb.b_valid && !grant_b) begin
            if (starve_q == STARVE_LAST) begin
              starve_q <= '0;
              state_q  <= FORCE_B;
            end else begin
              starve_q <= starve_q + 1'b1;
            end
          end else begin
            starve_q <= '0;
          end
        end
        FORCE_B: begin
          starve_q <= '0;
          state_q  <= PRI_A;
        end
        default: begin
          starve_q <= '0;
          state_q  <= PRI_A;
        end
      endcase
    end
  end

  assign wb.rf_reg_write  = rf_we_q;
  assign wb.rf_rd         = rf_rd_q;
  assign wb.rf_write_data = rf_data_q;

`ifdef RF_WB_SCOREBOARD_EN
  rf_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst),
    .alloc_i    (wb.sb_alloc),
    .alloc_rd_i (wb.sb_alloc_rd),
    .clr_i      (grant_a || grant_b),
    .clr_rd_i   (win_rd),
    .busy_o     (wb.sb_busy)
  );
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized requesters against a wait-count model.
module tb_rf_wb_arbiter;
  localparam int SM = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  rf_wb_arbiter #(.XLEN(32), .REG_AW(5), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: number of consecutive cycles B has been valid and lost, plus expected RF outputs.
  int          b_wait;
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic [31:0] exp_busy;
  logic        ga_m, gb_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    b_wait   = 0;
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_busy = '0;
  endtask

  // Called at posedge+1: drive, check readies, clock, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic al, input logic [4:0] ald);
    bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
    bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
`ifdef RF_WB_SCOREBOARD_EN
    bus.sb_alloc = al; bus.sb_alloc_rd = ald;
`endif
    #3;
    gb_m = bv && (b_wait >= SM || !av);
    ga_m = av && !gb_m;
    check("a_ready", bus.a_ready, ga_m);
    check("b_ready", bus.b_ready, gb_m);
    check("one_grant", bus.a_ready & bus.b_ready, 0);
    @(posedge clk);
    if (ga_m && ard != 0) begin
      exp_we = 1'b1; exp_rd = ard; exp_data = ad;
    end else if (gb_m && brd != 0) begin
      exp_we = 1'b1; exp_rd = brd; exp_data = bd;
    end else begin
      exp_we = 1'b0;
    end
    if (ga_m && ard != 0) exp_busy[ard] = 1'b0;
    if (gb_m && brd != 0) exp_busy[brd] = 1'b0;
    if (al && ald != 0) exp_busy[ald] = 1'b1;
    b_wait = (bv && !gb_m) ? b_wait + 1 : 0;
    #1;
    check("rf_reg_write", bus.rf_reg_write, exp_we);
    check("rf_rd", bus.rf_rd, exp_rd);
    check("rf_write_data", bus.rf_write_data, exp_data);
`ifdef RF_WB_SCOREBOARD_EN
    check("sb_busy", bus.sb_busy, exp_busy);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        a_pend, b_pend;
    logic [4:0]  ra_rd, rb_rd;
    logic [31:0] ra_d, rb_d;

    model_reset();
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h55;
    bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h66;
`ifdef RF_WB_SCOREBOARD_EN
    bus.sb_alloc = 1'b0; bus.sb_alloc_rd = '0;
`endif
    rst = 1'b0;
    #2;
    check("rst_we", bus.rf_reg_write, 0);
    check("rst_rd", bus.rf_rd, 0);
    check("rst_data", bus.rf_write_data, 0);
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_b_ready", bus.b_ready, 0);
`ifdef RF_WB_SCOREBOARD_EN
    check("rst_busy", bus.sb_busy, 0);
`endif
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // A alone, then rd==0 discard, then idle.
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Both valid continuously: A,A,A,A,B repeating; B holds its request until granted.
    rb_rd = 5'd10; rb_d = 32'hB000_0000;
    for (int i = 0; i < 12; i++) begin
      step(1, 5'(i + 1), 32'hA000_0000 + i, 1, rb_rd, rb_d, 0, 0);
      if (gb_m) begin rb_rd = rb_rd + 5'd1; rb_d = rb_d + 1; end
    end

    // B loses 3 times, withdraws, then needs a full SM losses again.
    for (int i = 0; i < 3; i++) step(1, 5'd2, 32'h20 + i, 1, 5'd12, 32'hC0, 0, 0);
    step(1, 5'd2, 32'h30, 0, 0, 0, 0, 0);
    for (int i = 0; i < SM + 1; i++) step(1, 5'd3, 32'h40 + i, 1, 5'd13, 32'hC1, 0, 0);
    check("force_b_after_full_wait", gb_m, 1);

    // Async reset mid-cycle while a write is being presented.
    step(1, 5'd9, 32'h9999_0009, 0, 0, 0, 0, 0);
    bus.a_valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_we", bus.rf_reg_write, 0);
    check("mid_rst_rd", bus.rf_rd, 0);
    check("mid_rst_data", bus.rf_write_data, 0);
    check("mid_rst_a_ready", bus.a_ready, 0);
    bus.a_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0, 0);
    check("post_rst_a_wins", ga_m, 1);
    step(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);

`ifdef RF_WB_SCOREBOARD_EN
    step(0, 0, 0, 0, 0, 0, 1, 5'd7);
    step(0, 0, 0, 1, 5'd7, 32'h7777, 1, 5'd7);
    step(0, 0, 0, 1, 5'd7, 32'h7778, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd0);
`endif

    // Randomized requesters obeying hold-until-ready.
    a_pend = 1'b0; b_pend = 1'b0;
    ra_rd = '0; ra_d = '0; rb_rd = '0; rb_d = '0;
    for (int i = 0; i < 400; i++) begin
      logic al;
      logic [4:0] ald;
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; ra_rd = 5'($urandom); ra_d = $urandom;
      end
      if (!b_pend && $urandom_range(0, 2) != 0) begin
        b_pend = 1'b1; rb_rd = 5'($urandom); rb_d = $urandom;
      end
      al  = 1'($urandom);
      ald = 5'($urandom);
      step(a_pend, ra_rd, ra_d, b_pend, rb_rd, rb_d, al, ald);
      if (ga_m) a_pend = 1'b0;
      if (gb_m) b_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers. Requester A is the in-order pipeline write-back; requester B is the long-latency unit (load/mul-div). A fixed-priority policy with starvation protection picks one winner per cycle, and the winner drives a registered write to the register file. An optional scoreboard tracks registers with in-flight writes so the issue stage can stall on them.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register index width (NUM_REGS = 2**REG_AW)
- STARVE_MAX, 4, consecutive cycles B may lose before it is forced to win (≥1)

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  A has a write pending
- a_ready  out  1  A is granted this cycle
- a_rd  in  REG_AW  A destination register
- a_data  in  XLEN  A write data
- b_valid, b_ready, b_rd, b_data  same as the A ports, for requester B
- rf_reg_write  out  1  register file write enable (registered)
- rf_rd  out  REG_AW  register file destination (registered)
- rf_write_data  out  XLEN  register file write data (registered)
- sb_alloc  in  1  issue stage claims a destination (RF_WB_SCOREBOARD_EN only)
- sb_alloc_rd  in  REG_AW  claimed register (RF_WB_SCOREBOARD_EN only)
- sb_busy  out  NUM_REGS  one bit per register with a write in flight (RF_WB_SCOREBOARD_EN only)

## Operation
- Handshake is valid/ready:
  - A transfer completes when valid && ready.
  - Once valid is raised, the requester holds it, along with rd and data, until ready.
  - Ready is combinational from the valids and the arbiter state. It never depends on this cycle's ready of the other requester.
- Arbiter FSM:
  - PRI_A (the reset state):
    - A wins if a_valid; otherwise B wins if b_valid.
    - starve_cnt increments each cycle that b_valid && !b_ready.
    - When starve_cnt == STARVE_MAX-1 and B loses again, starve_cnt resets and the FSM moves to FORCE_B.
  - FORCE_B:
    - B wins if b_valid; A waits even if a_valid.
    - Returns to PRI_A after a B grant, or immediately if b_valid is low.
  - starve_cnt clears on any B grant or whenever b_valid is low.
  - starve_cnt width is $clog2(STARVE_MAX+1).
- At most one grant per cycle; a_ready && b_ready is never 1.
- Write path:
  - A grant with rd != 0 registers rf_reg_write=1, rf_rd and rf_write_data at the next edge.
  - A grant with rd == 0 is accepted (ready=1) and discarded; rf_reg_write stays 0 and x0 is never written.
  - With no grant, rf_reg_write=0 next cycle. rf_rd and rf_write_data hold their previous values.
- The register file never back-pressures, so the output stage is never stalled.

## Timing
- Latency: 1 cycle from a handshake to rf_reg_write.
- Maximum throughput is one write per cycle.
- Reset (rst low, asynchronous):
  - rf_reg_write=0, rf_rd=0, rf_write_data=0.
  - FSM=PRI_A, starve_cnt=0, sb_busy=0.
  - a_ready and b_ready read 0 while rst is low.
- Reset asserted mid-operation:
  - A write registered but not yet consumed is lost.
  - Requesters must re-present their requests after reset.
- Worst-case B wait while A is continuously valid is STARVE_MAX cycles; B is granted in cycle STARVE_MAX (0-based).
- A worst-case wait under continuous B is 1 cycle per forced B grant.

## Configuration
- RF_WB_SCOREBOARD_EN defined:
  - sb_alloc, sb_alloc_rd and sb_busy exist.
  - sb_alloc with sb_alloc_rd != 0 sets sb_busy[rd] at the next edge.
  - A write-back handshake with rd != 0 clears sb_busy[rd] at the same edge that registers the write.
  - When alloc and clear hit the same register in the same cycle, alloc wins and the bit stays 1.
  - sb_busy[0] is constant 0.
- Not defined: the three sb_* ports and all scoreboard state are absent. Arbiter behaviour is identical either way.

## Structure
- Shared package rf_pkg holds:
  - XLEN, REG_AW and NUM_REGS constants.
  - The arbiter state typedef (PRI_A, FORCE_B).
- Sub-module rf_scoreboard holds the busy vector plus set/clear logic. It is instantiated only under RF_WB_SCOREBOARD_EN.
- The arbiter FSM, starve counter and output register stay in rf_wb_arbiter.

## Test plan
1. A alone, a_rd=5, a_data=0xDEADBEEF → a_ready=1 the same cycle; next cycle rf_reg_write=1, rf_rd=5, rf_write_data=0xDEADBEEF.
2. A and B valid continuously with STARVE_MAX=4 → grant sequence A,A,A,A,B,A,A,A,A,B,…; a_ready and b_ready are never both 1.
3. A with rd=0, data=0x1234 → a_ready=1; rf_reg_write stays 0 the next cycle.
4. B losing for 3 cycles, then b_valid dropped → FSM stays PRI_A and starve_cnt=0. B re-asserted later needs a full 4 losses before it is forced.
5. rst pulled low asynchronously mid-cycle while rf_reg_write=1 → all outputs are 0 immediately. After release, simultaneous A/B requests grant A.
6. With RF_WB_SCOREBOARD_EN:
   - sb_alloc rd=7 → sb_busy[7]=1 next cycle.
   - B writes rd=7 while a new alloc of rd=7 arrives in the same cycle → sb_busy[7] stays 1.
   - A following write of rd=7 with no alloc → sb_busy[7]=0.
   - sb_alloc rd=0 → sb_busy[0]=0.
